// File: rtl/encout_apb_cfg_seq.sv
// encout_apb_cfg_seq: APB3 master that programs the ENCOUT register block.
// One accepted i_start writes CTL, OPT, POSMAX, OUTCNT, PERIOD, then STR,
// and polls STATUS until (prdata & STATUS_MASK) != 0.
// Optional feature macro: ENCOUT_SEQ_READBACK_EN. When it is defined, each
// CTL..PERIOD write is followed by a read of the same address, and that read
// must return the written value.
// Ports:
//   i_pclk, i_presetn      clock, async active-low reset
//   i_start                start pulse, accepted only when idle
//   i_ctl .. i_str         write values, captured when the start is accepted
//   o_paddr/o_psel/o_penable/o_pwrite/o_pwdata, i_pready/i_pslverr/i_prdata  APB3
//   o_busy                 sequence in progress
//   o_done                 one-cycle success pulse
//   o_err, o_err_code      sticky error flag and code (01 slverr, 10 timeout, 11 readback)
`timescale 1ns/1ps
module encout_apb_cfg_seq #(
  parameter logic [31:0] ADR_BASE    = 32'hA011_C100,
  parameter logic [31:0] STATUS_MASK = 32'h0000_0001,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned POLL_MAX    = 16
) (
  input  logic        i_pclk,
  input  logic        i_presetn,
  input  logic        i_start,
  input  logic [31:0] i_ctl,
  input  logic [31:0] i_opt,
  input  logic [31:0] i_posmax,
  input  logic [31:0] i_outcnt,
  input  logic [31:0] i_period,
  input  logic [31:0] i_str,
  output logic [31:0] o_paddr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  input  logic        i_pready,
  input  logic        i_pslverr,
  input  logic [31:0] i_prdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

`ifdef ENCOUT_SEQ_READBACK_EN
  localparam int unsigned LAST_IDX = 11;
`else
  localparam int unsigned LAST_IDX = 6;
`endif
  localparam int unsigned IW = 4;
  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [1:0] E_SLV = 2'b01;
  localparam logic [1:0] E_TMO = 2'b10;
`ifdef ENCOUT_SEQ_READBACK_EN
  localparam logic [1:0] E_RDB = 2'b11;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_POLL_WAIT, S_DONE, S_ERR
  } state_t;

  // Transfer index -> {is_read, register select}; select 6 is STATUS.
  function automatic logic [3:0] f_decode(input logic [IW-1:0] idx);
`ifdef ENCOUT_SEQ_READBACK_EN
    if (idx < IW'(10))       f_decode = {idx[0], idx[3:1]};
    else if (idx == IW'(10)) f_decode = {1'b0, 3'd5};
    else                     f_decode = {1'b1, 3'd6};
`else
    if (idx < IW'(6)) f_decode = {1'b0, idx[2:0]};
    else              f_decode = {1'b1, 3'd6};
`endif
  endfunction

  // Register select -> address offset from ADR_BASE.
  function automatic logic [31:0] f_offset(input logic [2:0] sel);
    case (sel)
      3'd0:    f_offset = 32'h000;
      3'd1:    f_offset = 32'h002;
      3'd2:    f_offset = 32'h006;
      3'd3:    f_offset = 32'h00C;
      3'd4:    f_offset = 32'h00E;
      3'd5:    f_offset = 32'h001;
      default: f_offset = 32'hC0A;
    endcase
  endfunction

  // Register select -> value to write (from the shadow set).
  function automatic logic [31:0] f_word(input logic [2:0] sel, input logic [5:0][31:0] src);
    case (sel)
      3'd0:    f_word = src[0];
      3'd1:    f_word = src[1];
      3'd2:    f_word = src[2];
      3'd3:    f_word = src[3];
      3'd4:    f_word = src[4];
      3'd5:    f_word = src[5];
      default: f_word = 32'h0;
    endcase
  endfunction

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [PW-1:0]     r_poll, w_poll_nxt;
  logic [GW-1:0]     r_gap, w_gap_nxt;
  logic [1:0]        w_code_nxt;
  logic [5:0][31:0]  r_shadow;
  logic [5:0][31:0]  w_inputs, w_src;
  logic              w_accept;
  logic [3:0]        w_nxt_dec;
`ifdef ENCOUT_SEQ_READBACK_EN
  logic [3:0]        w_cur_dec;
`endif

  logic [31:0] r_paddr, w_paddr, r_pwdata, w_pwdata;
  logic        r_psel, w_psel, r_penable, w_penable, r_pwrite, w_pwrite;
  logic        r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [1:0]  r_err_code, w_err_code;

  assign w_inputs  = {i_str, i_period, i_outcnt, i_posmax, i_opt, i_ctl};
  assign w_accept  = (r_state == S_IDLE) && i_start;
  // First SETUP is launched on the accept edge, before the shadow regs load.
  assign w_src     = w_accept ? w_inputs : r_shadow;
  assign w_nxt_dec = f_decode(w_idx_nxt);
`ifdef ENCOUT_SEQ_READBACK_EN
  assign w_cur_dec = f_decode(r_idx);
`endif

  // State, counters, shadow and registered outputs.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_poll     <= '0;
      r_gap      <= '0;
      r_shadow   <= '0;
      r_paddr    <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_poll     <= w_poll_nxt;
      r_gap      <= w_gap_nxt;
      if (w_accept) r_shadow <= w_inputs;
      r_paddr    <= w_paddr;
      r_psel     <= w_psel;
      r_penable  <= w_penable;
      r_pwrite   <= w_pwrite;
      r_pwdata   <= w_pwdata;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err_code;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_poll_nxt  = r_poll;
    w_gap_nxt   = r_gap;
    w_code_nxt  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = '0;
          w_poll_nxt  = '0;
          w_gap_nxt   = '0;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (i_pready) begin
          if (i_pslverr) begin
            w_state_nxt = S_ERR;
            w_code_nxt  = E_SLV;
          end
`ifdef ENCOUT_SEQ_READBACK_EN
          else if (w_cur_dec[3] && (w_cur_dec[2:0] != 3'd6) &&
                   (i_prdata != f_word(w_cur_dec[2:0], r_shadow))) begin
            w_state_nxt = S_ERR;
            w_code_nxt  = E_RDB;
          end
`endif
          else if (r_idx == IW'(LAST_IDX)) begin
            if ((i_prdata & STATUS_MASK) != '0) begin
              w_state_nxt = S_DONE;
            end else if (r_poll >= PW'(POLL_MAX - 1)) begin
              w_state_nxt = S_ERR;
              w_code_nxt  = E_TMO;
            end else begin
              w_state_nxt = S_POLL_WAIT;
              w_gap_nxt   = '0;
              if (r_poll != PW'(POLL_MAX)) w_poll_nxt = r_poll + PW'(1);
            end
          end else begin
            w_state_nxt = S_SETUP;
            w_idx_nxt   = r_idx + IW'(1);
          end
        end
      end
      S_POLL_WAIT: begin
        if (r_gap == GW'(POLL_GAP - 1)) w_state_nxt = S_SETUP;
        else                            w_gap_nxt   = r_gap + GW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    w_psel     = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable  = (w_state_nxt == S_ACCESS);
    w_busy     = w_psel || (w_state_nxt == S_POLL_WAIT);
    w_done     = (w_state_nxt == S_DONE);
    w_paddr    = r_paddr;
    w_pwrite   = r_pwrite;
    w_pwdata   = r_pwdata;
    w_err      = r_err;
    w_err_code = r_err_code;
    // Address and data change only on entry to SETUP, so they hold through ACCESS.
    if (w_state_nxt == S_SETUP) begin
      w_paddr  = ADR_BASE + f_offset(w_nxt_dec[2:0]);
      w_pwrite = ~w_nxt_dec[3];
      w_pwdata = w_nxt_dec[3] ? 32'h0 : f_word(w_nxt_dec[2:0], w_src);
    end
    if (w_accept) begin
      w_err      = 1'b0;
      w_err_code = 2'b00;
    end
    if (w_state_nxt == S_ERR) begin
      w_err      = 1'b1;
      w_err_code = w_code_nxt;
    end
  end

  assign o_paddr    = r_paddr;
  assign o_psel     = r_psel;
  assign o_penable  = r_penable;
  assign o_pwrite   = r_pwrite;
  assign o_pwdata   = r_pwdata;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
